// File: rtl/bios_load_arbiter.sv
// Shares one single-port BIOS RAM between the HPS download path and the CPU.
// Holds the CPU in reset during a download and for RST_HOLD cycles afterwards.
module bios_load_arbiter #(
  parameter logic [7:0]  BIOS_INDEX = 8'd0,
  parameter int unsigned RST_HOLD   = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic [7:0]  dn_index,
  input  logic        dn_wr,
  input  logic [13:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic [13:0] cpu_addr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_dout,
  output logic        cpu_valid,
  output logic        cpu_reset,
  output logic [13:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  output logic [14:0] byte_count,
  output logic        load_done,
  output logic        overflow
);

  localparam logic [15:0] HOLD_CYCLES = 16'(RST_HOLD);
  localparam logic [14:0] MAX_COUNT   = 15'd16384;

  typedef enum logic [1:0] {HOLD, IDLE, LOAD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_rst_sync;
  logic [15:0] r_cnt;
  logic [13:0] r_ram_addr;
  logic [7:0]  r_ram_din;
  logic        r_ram_we;
  logic        r_cpu_valid;
  logic [7:0]  r_dout_last;
  logic [14:0] r_byte_count;
  logic        r_load_done;
  logic        r_overflow;

  logic w_run;
  logic w_match;
  logic w_entry;
  logic w_exit;
  logic w_accept;
  logic w_rd;

  // Release is synchronised; assertion still acts asynchronously on every flop.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run   = r_rst_sync[1];
  assign w_match = dn_download && (dn_index == BIOS_INDEX);
  assign w_entry = (r_state == IDLE) && w_match;
  assign w_exit  = (r_state == LOAD) && !w_match;
  // The LOAD-entry cycle already accepts a strobe so a download that starts
  // with a write in its very first cycle loses no byte.
  assign w_accept = dn_wr && w_match && (r_state != HOLD);
  assign w_rd     = (r_state == IDLE) && cpu_rd;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= HOLD;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      HOLD:    if (w_run && (r_cnt <= 16'd1)) w_state_nxt = IDLE;
      IDLE:    if (w_match) w_state_nxt = LOAD;
      LOAD:    if (!w_match) w_state_nxt = HOLD;
      default: w_state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= HOLD_CYCLES;
    end else if (w_exit) begin
      r_cnt <= HOLD_CYCLES;
    end else if ((r_state == HOLD) && w_run && (r_cnt > 16'd1)) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // Write strobes are registered and issued one cycle later; CPU reads drive
  // the address combinationally and leave it behind in the address register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_cpu_valid <= 1'b0;
      r_dout_last <= '0;
    end else begin
      r_ram_we    <= w_accept;
      r_cpu_valid <= w_rd;
      if (w_accept) begin
        r_ram_addr <= dn_addr;
        r_ram_din  <= dn_data;
      end else if (w_rd) begin
        r_ram_addr <= cpu_addr;
      end
      if (r_cpu_valid) r_dout_last <= ram_dout;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_count <= '0;
      r_load_done  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_entry) begin
        r_byte_count <= {14'd0, w_accept};
        r_overflow   <= 1'b0;
        r_load_done  <= 1'b0;
      end else if (w_accept) begin
        if (r_byte_count == MAX_COUNT) r_overflow   <= 1'b1;
        else                           r_byte_count <= r_byte_count + 15'd1;
      end
      if (w_exit) r_load_done <= (r_byte_count != 15'd0);
    end
  end

  assign ram_addr   = w_rd ? cpu_addr : r_ram_addr;
  assign ram_din    = r_ram_din;
  assign ram_we     = r_ram_we;
  assign cpu_valid  = r_cpu_valid;
  assign cpu_dout   = r_cpu_valid ? ram_dout : r_dout_last;
  assign cpu_reset  = (r_state != IDLE);
  assign byte_count = r_byte_count;
  assign load_done  = r_load_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_bios_load_arbiter.sv
// Bench for bios_load_arbiter: directed tables, hand sequences and a randomized
// phase checked against a transaction-level model with a behavioural RAM.
module tb_bios_load_arbiter;
  localparam int RST_HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dn_download;
  logic [7:0]  dn_index;
  logic        dn_wr;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  logic [13:0] cpu_addr;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic        cpu_valid;
  logic        cpu_reset;
  logic [13:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [14:0] byte_count;
  logic        load_done;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  bios_load_arbiter #(.BIOS_INDEX(8'd0), .RST_HOLD(RST_HOLD)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dn_download(dn_download),
    .dn_index(dn_index), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_dout(cpu_dout),
    .cpu_valid(cpu_valid), .cpu_reset(cpu_reset), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .byte_count(byte_count), .load_done(load_done), .overflow(overflow)
  );

  // Single-port RAM, read-first, one-cycle read latency
  bit [7:0] mem [16384];
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_inputs();
    dn_download = 1'b0; dn_index = 8'd0; dn_wr = 1'b0; dn_addr = '0;
    dn_data = '0; cpu_addr = '0; cpu_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cpu_reset === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", 32'(cpu_reset), 32'd0);
  endtask

  // Transaction-level reference model for the randomized phase
  bit       m_load;
  int       m_hold;
  int       m_cnt;
  bit       m_ovf;
  bit       m_done;
  bit [7:0] sh [16384];

  task automatic rand_cycle(input bit rnd);
    bit          match, idle, acc, rd, e_valid;
    logic [13:0] e_a;
    logic [7:0]  e_d, e_dout;
    if (rnd) begin
      if ($urandom_range(15) == 0) dn_download = ~dn_download;
      dn_index = ($urandom_range(9) == 0) ? 8'd1 : 8'd0;
      dn_wr    = 1'($urandom_range(1));
      dn_addr  = 14'($urandom);
      dn_data  = 8'($urandom);
      cpu_rd   = 1'($urandom_range(1));
      cpu_addr = 14'($urandom);
    end else begin
      clear_inputs();
    end
    match   = dn_download && (dn_index == 8'd0);
    idle    = !m_load && (m_hold == 0);
    acc     = dn_wr && match && (m_load || idle);
    rd      = idle && cpu_rd;
    e_a     = dn_addr;
    e_d     = dn_data;
    e_valid = rd;
    e_dout  = sh[cpu_addr];
    if (acc) sh[dn_addr] = dn_data;
    if (idle && match) begin
      m_cnt = acc ? 1 : 0; m_ovf = 0; m_done = 0; m_load = 1;
    end else if (m_load && !match) begin
      m_done = (m_cnt > 0); m_load = 0; m_hold = RST_HOLD;
    end else if (acc) begin
      if (m_cnt == 16384) m_ovf = 1; else m_cnt++;
    end else if (!m_load && m_hold > 0) begin
      m_hold--;
    end
    tick();
    chk("rnd_cpu_reset", 32'(cpu_reset), 32'(m_load || m_hold > 0));
    chk("rnd_ram_we", 32'(ram_we), 32'(acc));
    if (acc) begin
      chk("rnd_ram_addr", 32'(ram_addr), 32'(e_a));
      chk("rnd_ram_din", 32'(ram_din), 32'(e_d));
    end
    chk("rnd_cpu_valid", 32'(cpu_valid), 32'(e_valid));
    if (e_valid) chk("rnd_cpu_dout", 32'(cpu_dout), 32'(e_dout));
    chk("rnd_byte_count", 32'(byte_count), m_cnt);
    chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
    chk("rnd_load_done", 32'(load_done), 32'(m_done));
  endtask

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  data;
    logic        exp_we;
    logic [13:0] exp_addr;
    logic [7:0]  exp_din;
    logic [14:0] exp_cnt;
  } wvec_t;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  exp_dout;
  } rvec_t;

  initial begin
    wvec_t wv [5];
    rvec_t rv [4];
    int    n;
    int    nwe;

    wv[0] = '{1'b1, 14'd0, 8'hA5, 1'b1, 14'd0, 8'hA5, 15'd1};
    wv[1] = '{1'b1, 14'd1, 8'h5A, 1'b1, 14'd1, 8'h5A, 15'd2};
    wv[2] = '{1'b1, 14'd2, 8'hFF, 1'b1, 14'd2, 8'hFF, 15'd3};
    wv[3] = '{1'b1, 14'd3, 8'h00, 1'b1, 14'd3, 8'h00, 15'd4};
    wv[4] = '{1'b0, 14'd0, 8'h00, 1'b0, 14'd0, 8'h00, 15'd4};
    rv[0] = '{14'd2, 8'hFF};
    rv[1] = '{14'd0, 8'hA5};
    rv[2] = '{14'd1, 8'h5A};
    rv[3] = '{14'd3, 8'h00};

    // Reset values
    reset_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Release: two synchroniser edges, then RST_HOLD counting edges
    reset_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (cpu_reset === 1'b1 && n < 100);
    chk("release_hold_edges", n, RST_HOLD + 2);
    chk("release_byte_count", 32'(byte_count), 32'd0);
    chk("release_load_done", 32'(load_done), 32'd0);
    chk("release_overflow", 32'(overflow), 32'd0);

    // Four-byte download at index 0, a write on every cycle
    dn_download = 1'b1; dn_index = 8'd0;
    tick();
    chk("load_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("load_entry_count", 32'(byte_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      dn_wr = wv[i].wr; dn_addr = wv[i].addr; dn_data = wv[i].data;
      tick();
      chk("load_we", 32'(ram_we), 32'(wv[i].exp_we));
      if (wv[i].exp_we) begin
        chk("load_addr", 32'(ram_addr), 32'(wv[i].exp_addr));
        chk("load_din", 32'(ram_din), 32'(wv[i].exp_din));
      end
      chk("load_count", 32'(byte_count), 32'(wv[i].exp_cnt));
      chk("load_cpu_reset_hold", 32'(cpu_reset), 32'd1);
    end
    dn_download = 1'b0; dn_wr = 1'b0;
    tick();
    chk("exit_byte_count", 32'(byte_count), 32'd4);
    chk("exit_load_done", 32'(load_done), 32'd1);
    chk("exit_overflow", 32'(overflow), 32'd0);
    n = 0;
    while (cpu_reset === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("post_load_hold_cycles", n, RST_HOLD);
    chk("mem_byte2", 32'(mem[2]), 32'hFF);

    // Non-matching index is ignored and stays in IDLE
    dn_download = 1'b1; dn_index = 8'd1;
    for (int k = 0; k < 4; k++) begin
      dn_wr = 1'b1; dn_addr = 14'(k + 8); dn_data = 8'(8'h40 + k);
      tick();
      chk("idx1_ram_we", 32'(ram_we), 32'd0);
      chk("idx1_cpu_reset", 32'(cpu_reset), 32'd0);
    end
    clear_inputs();
    tick();
    chk("idx1_byte_count", 32'(byte_count), 32'd4);
    chk("idx1_load_done", 32'(load_done), 32'd1);

    // IDLE reads
    for (int i = 0; i < 4; i++) begin
      cpu_rd = 1'b1; cpu_addr = rv[i].addr;
      #1;
      chk("rd_ram_addr", 32'(ram_addr), 32'(rv[i].addr));
      chk("rd_ram_we", 32'(ram_we), 32'd0);
      tick();
      cpu_rd = 1'b0;
      chk("rd_valid", 32'(cpu_valid), 32'd1);
      chk("rd_dout", 32'(cpu_dout), 32'(rv[i].exp_dout));
      tick();
      chk("rd_valid_drop", 32'(cpu_valid), 32'd0);
    end

    // Read in flight on the cycle the download starts
    cpu_rd = 1'b1; cpu_addr = 14'd1;
    dn_download = 1'b1; dn_index = 8'd0; dn_wr = 1'b1; dn_addr = 14'h10; dn_data = 8'h3C;
    #1;
    chk("start_rd_addr", 32'(ram_addr), 32'd1);
    chk("start_rd_we", 32'(ram_we), 32'd0);
    tick();
    chk("start_valid", 32'(cpu_valid), 32'd1);
    chk("start_dout", 32'(cpu_dout), 32'h5A);
    chk("start_we", 32'(ram_we), 32'd1);
    chk("start_wr_addr", 32'(ram_addr), 32'h10);
    chk("start_wr_din", 32'(ram_din), 32'h3C);
    chk("start_count", 32'(byte_count), 32'd1);
    cpu_addr = 14'h3FF; dn_addr = 14'h11; dn_data = 8'hC3;
    #1;
    chk("load_rd_ignored_addr", 32'(ram_addr), 32'h10);
    tick();
    chk("load_rd_no_valid", 32'(cpu_valid), 32'd0);
    chk("second_we", 32'(ram_we), 32'd1);
    chk("second_addr", 32'(ram_addr), 32'h11);
    chk("second_din", 32'(ram_din), 32'hC3);
    chk("second_count", 32'(byte_count), 32'd2);
    dn_wr = 1'b0; dn_download = 1'b0;
    tick();
    chk("start_exit_count", 32'(byte_count), 32'd2);
    chk("start_exit_done", 32'(load_done), 32'd1);
    tick();
    chk("hold_rd_no_valid", 32'(cpu_valid), 32'd0);
    cpu_rd = 1'b0;
    wait_idle();
    chk("mem_0x10", 32'(mem[16]), 32'h3C);
    chk("mem_0x11", 32'(mem[17]), 32'hC3);

    // 16385 writes: saturation and sticky overflow
    dn_download = 1'b1; dn_index = 8'd0;
    tick();
    nwe = 0;
    for (int i = 0; i <= 16384; i++) begin
      dn_wr = 1'b1; dn_addr = 14'(i); dn_data = 8'(i);
      tick();
      if (ram_we) nwe++;
      if (i == 16383) begin
        chk("sat_count_full", 32'(byte_count), 32'd16384);
        chk("sat_no_ovf_yet", 32'(overflow), 32'd0);
      end
      if (i == 16384) begin
        chk("sat_count_held", 32'(byte_count), 32'd16384);
        chk("sat_ovf", 32'(overflow), 32'd1);
        chk("sat_last_addr", 32'(ram_addr), 32'd0);
        chk("sat_last_we", 32'(ram_we), 32'd1);
      end
    end
    chk("sat_we_pulses", nwe, 16385);
    dn_wr = 1'b0;
    tick();
    dn_download = 1'b0;
    tick();
    chk("sat_exit_done", 32'(load_done), 32'd1);
    chk("sat_exit_ovf", 32'(overflow), 32'd1);
    wait_idle();

    // Randomized traffic against the model
    m_load = 0; m_hold = 0; m_cnt = 16384; m_ovf = 1; m_done = 1;
    sh = mem;
    clear_inputs();
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 40; c++) rand_cycle(1'b0);

    // Reset mid-load drops the pending write and clears status
    wait_idle();
    dn_download = 1'b1; dn_index = 8'd0;
    tick();
    dn_wr = 1'b1; dn_addr = 14'd5; dn_data = 8'h77;
    tick();
    chk("abort_pending_we", 32'(ram_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_we", 32'(ram_we), 32'd0);
    chk("abort_count", 32'(byte_count), 32'd0);
    chk("abort_done", 32'(load_done), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("abort_ram_addr", 32'(ram_addr), 32'd0);
    clear_inputs();
    tick();
    chk("abort_we_after_edge", 32'(ram_we), 32'd0);
    reset_n = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
